// File: rtl/riscv_pkg.sv
// Shared RV32I encodings, ALU/FSM enums and the ALU helper used by execute_stage.
package riscv_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BUBBLE = 7'h00;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, MUL_BUSY, MUL_DONE} exec_state_t;

    // alt picks SUB over ADD and SRA over SRL; it is ignored for every other func3.
    function automatic alu_op_t alu_decode(input logic [2:0] func3, input logic alt);
        alu_op_t op;
        case (func3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] alu_compute(input alu_op_t op, input logic [31:0] a,
                                                input logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'b0, a < b};
            ALU_XOR:  r = a ^ b;
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add 32x32->64 multiplier; one partial product per cycle, 32 cycles total.
module mul_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic        active;
    logic [5:0]  count;
    logic [63:0] acc;
    logic [63:0] mcand;
    logic [31:0] mplier;
    logic        negate;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    always_comb begin
        a_mag = (a_signed && a[31]) ? -a : a;
        b_mag = (b_signed && b[31]) ? -b : b;
    end

    // The start cycle already folds in multiplier bit 0, so 31 more steps finish the product.
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            negate <= 1'b0;
        end else if (start) begin
            active <= 1'b1;
            count  <= 6'd1;
            acc    <= b_mag[0] ? {32'b0, a_mag} : 64'b0;
            mcand  <= {31'b0, a_mag, 1'b0};
            mplier <= b_mag >> 1;
            negate <= (a_signed && a[31]) ^ (b_signed && b[31]);
        end else if (busy) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 6'd1;
        end
    end

    assign busy    = active && (count != 6'd32);
    assign done    = active && (count == 6'd32);
    assign product = negate ? -acc : acc;

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, branch/jump resolution and the registered bundle to mem.
// Define RV32M_MUL_EN to add the iterative MUL/MULH/MULHSU/MULHU unit.
module execute_stage
    import riscv_pkg::*;
#(
    parameter int          XLEN         = 32,
    parameter logic [31:0] RESET_PC_OUT = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [6:0]      i_opcode,
    input  logic [2:0]      i_func3,
    input  logic [6:0]      i_func7,
    input  logic [4:0]      i_rd_number,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [XLEN-1:0] i_immediate,
    input  logic            i_pipeline_stall,
    output logic            o_ready,
    output logic [4:0]      rd_number_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] rs1_val_out,
    output logic [XLEN-1:0] rs2_val_out,
    output logic [XLEN-1:0] immediate_out,
    output logic [6:0]      opcode_out,
    output logic [2:0]      func3_out,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_branch_target,
    output logic            o_illegal
);

    exec_state_t     state, state_next;
    logic            accept;
    logic            illegal_op;
    logic            is_mul;
    logic            taken;
    logic [XLEN-1:0] exec_result;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] rs1_plus_imm;
    logic [XLEN-1:0] pc_plus_imm;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;
    logic [4:0]      mul_rd;

    assign o_ready = !i_pipeline_stall && (state == IDLE);
    assign accept  = i_valid && o_ready;

    always_comb begin
        illegal_op      = 1'b0;
        is_mul          = 1'b0;
        taken           = 1'b0;
        exec_result     = '0;
        redirect_target = '0;
        rs1_plus_imm    = i_rs1_val + i_immediate;
        pc_plus_imm     = i_pc + i_immediate;
        case (i_opcode)
            OP: begin
                if (i_func7 == F7_MULDIV) begin
`ifdef RV32M_MUL_EN
                    is_mul     = !i_func3[2];
                    illegal_op = i_func3[2];
`else
                    illegal_op = 1'b1;
`endif
                end else if (i_func7 == F7_ALT) begin
                    illegal_op = !((i_func3 == F3_ADD_SUB) || (i_func3 == F3_SRL_SRA));
                end else if (i_func7 != F7_BASE) begin
                    illegal_op = 1'b1;
                end
                exec_result = alu_compute(alu_decode(i_func3, i_func7[5]), i_rs1_val, i_rs2_val);
            end
            OP_IMM: begin
                exec_result = alu_compute(
                    alu_decode(i_func3, (i_func3 == F3_SRL_SRA) && i_immediate[10]),
                    i_rs1_val, i_immediate);
            end
            LUI:   exec_result = i_immediate;
            AUIPC: exec_result = pc_plus_imm;
            LOAD, STORE: exec_result = rs1_plus_imm;
            JAL: begin
                exec_result     = i_pc + 32'd4;
                redirect_target = pc_plus_imm;
                taken           = 1'b1;
            end
            JALR: begin
                exec_result     = i_pc + 32'd4;
                redirect_target = rs1_plus_imm & ~32'd1;
                taken           = 1'b1;
            end
            BRANCH: begin
                redirect_target = pc_plus_imm;
                case (i_func3)
                    F3_BEQ:  taken = (i_rs1_val == i_rs2_val);
                    F3_BNE:  taken = (i_rs1_val != i_rs2_val);
                    F3_BLT:  taken = ($signed(i_rs1_val) < $signed(i_rs2_val));
                    F3_BGE:  taken = ($signed(i_rs1_val) >= $signed(i_rs2_val));
                    F3_BLTU: taken = (i_rs1_val < i_rs2_val);
                    F3_BGEU: taken = (i_rs1_val >= i_rs2_val);
                    default: illegal_op = 1'b1;
                endcase
            end
            default: illegal_op = 1'b1;
        endcase
    end

`ifdef RV32M_MUL_EN
    logic        mul_busy;
    logic [63:0] mul_product;

    mul_iter u_mul_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && is_mul),
        .a_signed ((i_func3 == F3_MULH) || (i_func3 == F3_MULHSU)),
        .b_signed (i_func3 == F3_MULH),
        .a        (i_rs1_val),
        .b        (i_rs2_val),
        .busy     (mul_busy),
        .done     (mul_done),
        .product  (mul_product)
    );

    // func3_out was captured with the multiply and holds until the result is written.
    assign mul_result = (func3_out == F3_MUL) ? mul_product[31:0] : mul_product[63:32];
`else
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (accept && is_mul) state_next = MUL_BUSY;
`ifdef RV32M_MUL_EN
            MUL_BUSY: if (mul_done && !mul_busy && !i_pipeline_stall) state_next = MUL_DONE;
`else
            MUL_BUSY: if (mul_done && !i_pipeline_stall) state_next = MUL_DONE;
`endif
            MUL_DONE: if (!i_pipeline_stall) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Stalls freeze the bundle but kill the pulses so a redirect or illegal flag fires once.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_number_out   <= '0;
            result_out      <= '0;
            pc_out          <= RESET_PC_OUT;
            rs1_val_out     <= '0;
            rs2_val_out     <= '0;
            immediate_out   <= '0;
            opcode_out      <= BUBBLE;
            func3_out       <= '0;
            o_branch_taken  <= 1'b0;
            o_branch_target <= '0;
            o_illegal       <= 1'b0;
            mul_rd          <= '0;
        end else if (i_pipeline_stall) begin
            o_branch_taken <= 1'b0;
            o_illegal      <= 1'b0;
        end else begin
            o_branch_taken <= 1'b0;
            o_illegal      <= 1'b0;
            opcode_out     <= BUBBLE;
            rd_number_out  <= '0;
            if ((state == MUL_BUSY) && mul_done) begin
                result_out    <= mul_result;
                opcode_out    <= OP;
                rd_number_out <= mul_rd;
            end else if (accept) begin
                pc_out        <= i_pc;
                rs1_val_out   <= i_rs1_val;
                rs2_val_out   <= i_rs2_val;
                immediate_out <= i_immediate;
                func3_out     <= i_func3;
                if (illegal_op) begin
                    o_illegal <= 1'b1;
                end else if (is_mul) begin
                    mul_rd <= i_rd_number;
                end else begin
                    opcode_out      <= i_opcode;
                    rd_number_out   <= i_rd_number;
                    result_out      <= exec_result;
                    o_branch_taken  <= taken;
                    o_branch_target <= redirect_target;
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic vs. a behavioural model.
module tb_execute_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [6:0] C_OP = 7'b0110011, C_OPI = 7'b0010011, C_LUI = 7'b0110111;
    localparam logic [6:0] C_AUIPC = 7'b0010111, C_JAL = 7'b1101111, C_JALR = 7'b1100111;
    localparam logic [6:0] C_BR = 7'b1100011, C_LD = 7'b0000011, C_ST = 7'b0100011;

    logic clk = 1'b0;
    logic reset;
    logic i_valid, i_pipeline_stall;
    logic [31:0] i_pc, i_rs1_val, i_rs2_val, i_immediate;
    logic [6:0] i_opcode, i_func7;
    logic [2:0] i_func3;
    logic [4:0] i_rd_number;
    logic o_ready, o_branch_taken, o_illegal;
    logic [4:0] rd_number_out;
    logic [31:0] result_out, pc_out, rs1_val_out, rs2_val_out, immediate_out, o_branch_target;
    logic [6:0] opcode_out;
    logic [2:0] func3_out;

    int vectors = 0;
    int miscompares = 0;

    // Expected registered outputs; m_full means the bundle holds a real instruction.
    logic [6:0] m_opc;
    logic [4:0] m_rd;
    logic [31:0] m_res, m_pc, m_rs1, m_rs2, m_imm, m_tgt;
    logic [2:0] m_f3;
    logic m_taken, m_ill, m_full;

    execute_stage #(.XLEN(32), .RESET_PC_OUT(RST_PC)) dut (
        .clk(clk), .reset(reset), .i_valid(i_valid), .i_pc(i_pc), .i_opcode(i_opcode),
        .i_func3(i_func3), .i_func7(i_func7), .i_rd_number(i_rd_number),
        .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val), .i_immediate(i_immediate),
        .i_pipeline_stall(i_pipeline_stall), .o_ready(o_ready),
        .rd_number_out(rd_number_out), .result_out(result_out), .pc_out(pc_out),
        .rs1_val_out(rs1_val_out), .rs2_val_out(rs2_val_out), .immediate_out(immediate_out),
        .opcode_out(opcode_out), .func3_out(func3_out), .o_branch_taken(o_branch_taken),
        .o_branch_target(o_branch_target), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Architectural result of one instruction, computed in 64-bit integer arithmetic.
    function automatic void model_exec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, output logic legal, output logic [31:0] res,
                                       output logic taken, output logic [31:0] tgt);
        longint unsigned mask = 64'hFFFF_FFFF;
        longint unsigned ua, ub;
        longint sa, sb;
        int sh;
        logic alt;
        legal = 1'b1; res = '0; taken = 1'b0; tgt = '0; alt = 1'b0;
        ua = rs1;
        ub = (opc == C_OP || opc == C_BR) ? rs2 : imm;
        sa = longint'($signed(rs1));
        sb = (opc == C_OP || opc == C_BR) ? longint'($signed(rs2)) : longint'($signed(imm));
        sh = int'(ub % 32);
        case (opc)
            C_OP, C_OPI: begin
                if (opc == C_OP) begin
                    legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                    alt = (f7 == 7'h20);
                end else begin
                    alt = (f3 == 3'd5) && imm[10];
                end
                case (f3)
                    3'd0: res = alt ? 32'((ua - ub) & mask) : 32'((ua + ub) & mask);
                    3'd1: res = 32'((ua << sh) & mask);
                    3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
                    3'd3: res = (ua < ub) ? 32'd1 : 32'd0;
                    3'd4: res = 32'(ua ^ ub);
                    3'd5: res = alt ? 32'(sa >>> sh) : 32'(ua >> sh);
                    3'd6: res = 32'(ua | ub);
                    default: res = 32'(ua & ub);
                endcase
            end
            C_LUI:   res = imm;
            C_AUIPC: res = 32'((longint'(pc) + longint'(imm)) & mask);
            C_LD, C_ST: res = 32'((ua + longint'(imm)) & mask);
            C_JAL: begin
                res = 32'((longint'(pc) + 4) & mask);
                tgt = 32'((longint'(pc) + longint'(imm)) & mask);
                taken = 1'b1;
            end
            C_JALR: begin
                res = 32'((longint'(pc) + 4) & mask);
                tgt = 32'((ua + longint'(imm)) & mask) & 32'hFFFF_FFFE;
                taken = 1'b1;
            end
            C_BR: begin
                tgt = 32'((longint'(pc) + longint'(imm)) & mask);
                case (f3)
                    3'd0: taken = (ua == ub);
                    3'd1: taken = (ua != ub);
                    3'd4: taken = (sa < sb);
                    3'd5: taken = (sa >= sb);
                    3'd6: taken = (ua < ub);
                    3'd7: taken = (ua >= ub);
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase
        if (!legal) taken = 1'b0;
    endfunction

    task automatic modelReset();
        m_opc = 7'h00; m_rd = '0; m_res = '0; m_pc = RST_PC; m_rs1 = '0; m_rs2 = '0;
        m_imm = '0; m_f3 = '0; m_tgt = '0; m_taken = 1'b0; m_ill = 1'b0; m_full = 1'b0;
    endtask

    task automatic checkModel();
        checkOutput("opcode_out", 32'(opcode_out), 32'(m_opc));
        checkOutput("rd_number_out", 32'(rd_number_out), 32'(m_rd));
        checkOutput("o_branch_taken", 32'(o_branch_taken), 32'(m_taken));
        checkOutput("o_illegal", 32'(o_illegal), 32'(m_ill));
        if (m_full) begin
            checkOutput("result_out", result_out, m_res);
            checkOutput("pc_out", pc_out, m_pc);
            checkOutput("rs1_val_out", rs1_val_out, m_rs1);
            checkOutput("rs2_val_out", rs2_val_out, m_rs2);
            checkOutput("immediate_out", immediate_out, m_imm);
            checkOutput("func3_out", 32'(func3_out), 32'(m_f3));
            if (m_taken) checkOutput("o_branch_target", o_branch_target, m_tgt);
        end
    endtask

    // Drives one cycle (stage assumed idle), checks o_ready, clocks, updates the model, checks outputs.
    task automatic applyStimulus(input logic v, input logic st, input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] pc,
                                 input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        logic legal, tk;
        logic [31:0] res, tgt;
        i_valid = v; i_pipeline_stall = st; i_opcode = opc; i_func3 = f3; i_func7 = f7;
        i_rd_number = rd; i_pc = pc; i_rs1_val = rs1; i_rs2_val = rs2; i_immediate = imm;
        #1;
        checkOutput("o_ready", 32'(o_ready), 32'(!st));
        if (st) begin
            m_taken = 1'b0; m_ill = 1'b0;
        end else if (v) begin
            model_exec(opc, f3, f7, pc, rs1, rs2, imm, legal, res, tk, tgt);
            if (legal) begin
                m_opc = opc; m_rd = rd; m_res = res; m_pc = pc; m_rs1 = rs1; m_rs2 = rs2;
                m_imm = imm; m_f3 = f3; m_tgt = tgt; m_taken = tk; m_ill = 1'b0; m_full = 1'b1;
            end else begin
                m_opc = 7'h00; m_rd = '0; m_taken = 1'b0; m_ill = 1'b1; m_full = 1'b0;
            end
        end else begin
            m_opc = 7'h00; m_rd = '0; m_taken = 1'b0; m_ill = 1'b0; m_full = 1'b0;
        end
        @(posedge clk);
        #1;
        checkModel();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 7'h00, 3'd0, 7'h00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [31:0] a, b;
        logic [2:0] br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [6:0] opcodes [10] = '{C_OP, C_OPI, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR, C_LD, C_ST, 7'h7F};

        reset = 1'b1; i_valid = 1'b0; i_pipeline_stall = 1'b0; i_pc = '0; i_opcode = '0;
        i_func3 = '0; i_func7 = '0; i_rd_number = '0; i_rs1_val = '0; i_rs2_val = '0; i_immediate = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset o_ready", 32'(o_ready), 32'd1);
        checkOutput("reset pc_out", pc_out, RST_PC);
        checkOutput("reset result_out", result_out, 32'd0);
        checkOutput("reset opcode_out", 32'(opcode_out), 32'd0);
        checkOutput("reset o_branch_taken", 32'(o_branch_taken), 32'd0);
        checkOutput("reset o_illegal", 32'(o_illegal), 32'd0);
        checkOutput("reset rs2_val_out", rs2_val_out, 32'd0);
        reset = 1'b0;
        modelReset();

        $display("[TB] directed cases");
        applyStimulus(1'b1, 1'b0, C_OP, 3'd0, 7'h00, 5'd3, 32'h10, 32'h7FFF_FFFF, 32'd1, 32'd0);
        checkOutput("add overflow", result_out, 32'h8000_0000);
        checkOutput("add opcode", 32'(opcode_out), 32'(7'b0110011));
        checkOutput("add no redirect", 32'(o_branch_taken), 32'd0);
        idleCycle();

        applyStimulus(1'b1, 1'b0, C_OPI, 3'd0, 7'h00, 5'd4, 32'h14, 32'hFFFF_FFFF, 32'd0, 32'd1);
        checkOutput("addi carry dropped", result_out, 32'd0);

        applyStimulus(1'b1, 1'b0, C_BR, 3'd4, 7'h00, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'h20);
        checkOutput("blt taken", 32'(o_branch_taken), 32'd1);
        checkOutput("blt target", o_branch_target, 32'h120);
        idleCycle();
        checkOutput("blt pulse ends", 32'(o_branch_taken), 32'd0);
        applyStimulus(1'b1, 1'b0, C_BR, 3'd6, 7'h00, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd0, 32'h20);
        checkOutput("bltu not taken", 32'(o_branch_taken), 32'd0);

        applyStimulus(1'b1, 1'b0, C_JALR, 3'd0, 7'h00, 5'd1, 32'h40, 32'h1001, 32'd0, 32'd2);
        checkOutput("jalr link", result_out, 32'h44);
        checkOutput("jalr target", o_branch_target, 32'h1002);

        applyStimulus(1'b1, 1'b0, C_ST, 3'd2, 7'h00, 5'd0, 32'h50, 32'h200, 32'hDEAD, 32'hFFFF_FFFC);
        repeat (3) begin
            applyStimulus(1'b1, 1'b1, C_OP, 3'd0, 7'h00, 5'd9, 32'h54, 32'd5, 32'd6, 32'd0);
            checkOutput("stall holds address", result_out, 32'h1FC);
            checkOutput("stall holds store data", rs2_val_out, 32'hDEAD);
        end
        applyStimulus(1'b1, 1'b0, C_OP, 3'd0, 7'h00, 5'd9, 32'h54, 32'd5, 32'd6, 32'd0);
        checkOutput("add after stall", result_out, 32'd11);

        applyStimulus(1'b1, 1'b0, C_BR, 3'd0, 7'h00, 5'd0, 32'h200, 32'd5, 32'd5, 32'h10);
        checkOutput("beq taken", 32'(o_branch_taken), 32'd1);
        repeat (2) begin
            applyStimulus(1'b1, 1'b1, C_OP, 3'd0, 7'h00, 5'd2, 32'h204, 32'd1, 32'd1, 32'd0);
            checkOutput("branch pulse once under stall", 32'(o_branch_taken), 32'd0);
        end
        idleCycle();

        applyStimulus(1'b1, 1'b0, 7'b1111111, 3'd0, 7'h00, 5'd6, 32'h300, 32'd1, 32'd2, 32'd3);
        checkOutput("illegal pulse", 32'(o_illegal), 32'd1);
        checkOutput("illegal bubble", 32'(opcode_out), 32'd0);
        idleCycle();
        checkOutput("illegal pulse ends", 32'(o_illegal), 32'd0);
        applyStimulus(1'b1, 1'b0, C_OP, 3'd0, 7'h7F, 5'd6, 32'h304, 32'd1, 32'd2, 32'd3);
        checkOutput("illegal func7", 32'(o_illegal), 32'd1);

`ifdef RV32M_MUL_EN
        $display("[TB] multiply cases");
        i_valid = 1'b1; i_pipeline_stall = 1'b0; i_opcode = C_OP; i_func7 = 7'h01; i_func3 = 3'd1;
        i_rd_number = 5'd7; i_rs1_val = 32'hFFFF_FFFE; i_rs2_val = 32'd3;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        for (int c = 0; c < 32; c++) begin
            checkOutput("mul o_ready low", 32'(o_ready), 32'd0);
            checkOutput("mul busy bubble", 32'(opcode_out), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("mulh result", result_out, 32'hFFFF_FFFF);
        checkOutput("mulh opcode", 32'(opcode_out), 32'(C_OP));
        checkOutput("mulh rd", 32'(rd_number_out), 32'd7);
        @(posedge clk);
        #1;
        checkOutput("mul back to idle", 32'(o_ready), 32'd1);

        a = $urandom; b = $urandom;
        i_valid = 1'b1; i_func3 = 3'd3; i_rs1_val = a; i_rs2_val = b; i_rd_number = 5'd8;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        checkOutput("mulhu result", result_out, 32'(({32'b0, a} * {32'b0, b}) >> 32));

        i_valid = 1'b1; i_func3 = 3'd0;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("mul reset result", result_out, 32'd0);
        checkOutput("mul reset opcode", 32'(opcode_out), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("mul reset o_ready", 32'(o_ready), 32'd1);
        modelReset();
`else
        applyStimulus(1'b1, 1'b0, C_OP, 3'd1, 7'h01, 5'd7, 32'h400, 32'hFFFF_FFFE, 32'd3, 32'd0);
        checkOutput("mul illegal without unit", 32'(o_illegal), 32'd1);
`endif

        $display("[TB] random traffic");
        for (int n = 0; n < 300; n++) begin
            opc = opcodes[$urandom_range(0, 9)];
            f3 = 3'($urandom_range(0, 7));
            if (opc == C_BR) f3 = br_f3[$urandom_range(0, 5)];
            f7 = ($urandom_range(0, 3) == 0) ? 7'h20 : 7'h00;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, opc, f3, f7,
                          5'($urandom), $urandom & 32'hFFFF_FFFC, a, b, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
